operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 18, operand and register data width.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 4, register index width (16 registers).
REQ-003 SHALL have parameter OPCODE_WIDTH, default 4, opaque opcode width passed through unchanged.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: CPU_CLOCK input 1 (all state on rising edge); CLEAR input 1 (async active-high reset).
REQ-005 SHALL have upstream ports: IN_VALID input 1 (instruction offered); IN_READY output 1 (instruction accepted this cycle); IN_OPCODE input OPCODE_WIDTH; IN_SRC_1 and IN_SRC_2 input REG_ADDR_WIDTH (source indices); IN_USES_SRC input 2 (bit0 = source 1 read, bit1 = source 2 read); IN_DEST input REG_ADDR_WIDTH (destination index); IN_WRITES_DEST input 1 (instruction writes IN_DEST).
REQ-006 SHALL have register-file ports: READ_REG_1 and READ_REG_2 output REG_ADDR_WIDTH (combinational copies of IN_SRC_1/IN_SRC_2); READ_DATA_1 and READ_DATA_2 input DATA_WIDTH (combinational read data).
REQ-007 SHALL have writeback ports: WB_VALID input 1 (writeback this cycle); WB_REG input REG_ADDR_WIDTH; WB_DATA input DATA_WIDTH; these carry the same values that drive the register file write port.
REQ-008 SHALL have downstream ports: OUT_VALID output 1; OUT_READY input 1; OUT_OPCODE output OPCODE_WIDTH; OUT_OPERAND_1 and OUT_OPERAND_2 output DATA_WIDTH; OUT_DEST output REG_ADDR_WIDTH; OUT_WRITES_DEST output 1; PENDING output 2^REG_ADDR_WIDTH (scoreboard bitmap, debug).

Function
REQ-009 SHALL hold a one-entry output register; an accepted instruction appears on OUT_* exactly one cycle after acceptance (latency 1).
REQ-010 SHALL treat the output as free when OUT_VALID=0, or when OUT_VALID=1 and OUT_READY=1 in the same cycle.
REQ-011 SHALL assert IN_READY only when the output is free and no hazard (REQ-013, REQ-014) exists; acceptance = IN_VALID and IN_READY.
REQ-012 SHALL keep a PENDING bitmap, one bit per register; bit r set means an accepted instruction with IN_WRITES_DEST=1 and IN_DEST=r has not yet been written back.
REQ-013 SHALL flag a RAW hazard when a used source s has PENDING[s]=1, unless WB_VALID=1 and WB_REG=s in the same cycle.
REQ-014 SHALL flag a WAW hazard when IN_WRITES_DEST=1 and PENDING[IN_DEST]=1, unless WB_VALID=1 and WB_REG=IN_DEST in the same cycle.
REQ-015 SHALL forward each operand: WB_DATA when WB_VALID=1 and WB_REG equals that source, else READ_DATA_n; unused sources capture 0.
REQ-016 SHALL, on acceptance, set PENDING[IN_DEST] when IN_WRITES_DEST=1; on WB_VALID=1, clear PENDING[WB_REG].
REQ-017 SHALL let the set win when the set and the clear hit the same bit in the same cycle.
REQ-018 SHALL ignore WB_VALID for a register whose PENDING bit is already 0; no error and no other state change.
REQ-019 SHALL clear OUT_VALID after a downstream handshake when nothing is accepted that cycle; OUT_* data SHALL hold while OUT_VALID=1 and OUT_READY=0.
REQ-020 SHALL NOT let IN_READY depend on IN_VALID; IN_READY SHALL depend combinationally on OUT_VALID, OUT_READY, PENDING, WB_VALID, WB_REG and the IN_* fields only.

Reset
REQ-021 SHALL, while CLEAR=1, immediately force OUT_VALID=0, OUT_OPCODE=0, OUT_OPERAND_1=0, OUT_OPERAND_2=0, OUT_DEST=0, OUT_WRITES_DEST=0 and PENDING=0, independent of CPU_CLOCK.
REQ-022 SHALL discard any held entry when CLEAR is asserted mid-operation; the first acceptance is possible on the first rising edge after CLEAR deasserts.

Structure
REQ-023 SHALL take DATA_WIDTH=18, REG_ADDR_WIDTH=4, NUM_REGS=16 and OPCODE_WIDTH=4 from shared package cpu_pkg, also used by the register file and execute stage.
REQ-024 SHALL place the PENDING bitmap with its set/clear/hazard logic in sub-module reg_scoreboard; the pipeline register and forwarding stay in operand_fetch.

Verification
REQ-025 SHALL verify plain issue: R3=0x00005 and R4=0x00007, with no pending bits; issue src 3,4, dest 5 -> next cycle OUT_VALID=1, operands 0x00005/0x00007, PENDING=0x0020.
REQ-026 SHALL verify a RAW stall: with PENDING[5]=1, offer src1=5 -> IN_READY=0 each cycle; when WB_VALID=1, WB_REG=5, WB_DATA=0x3FFFF -> accepted that cycle, OUT_OPERAND_1=0x3FFFF, PENDING[5]=0.
REQ-027 SHALL verify back-pressure: OUT_READY=0 for 3 cycles with OUT_VALID=1 -> OUT_* stable and IN_READY=0; OUT_READY=1 plus a new IN_VALID -> back-to-back transfer with no bubble.
REQ-028 SHALL verify a WAW collision: PENDING[2]=1, WB to 2 in the same cycle an instruction with dest 2 is accepted -> PENDING[2]=1 afterwards (set wins).
REQ-029 SHALL verify reset mid-operation: OUT_VALID=1 and PENDING=0x8001, CLEAR pulsed between edges -> OUT_VALID=0 and PENDING=0 immediately, before the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-wide sizing constants, used by the register file, the operand
// fetch stage and the execute stage so that all of them agree on widths.
//   DATA_WIDTH     : register / operand width
//   REG_ADDR_WIDTH : register index width
//   NUM_REGS       : number of architectural registers
//   OPCODE_WIDTH   : opaque opcode width carried down the pipeline
package cpu_pkg;

  localparam int DATA_WIDTH     = 18;
  localparam int REG_ADDR_WIDTH = 4;
  localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH;
  localparam int OPCODE_WIDTH   = 4;

endpackage

// File: rtl/reg_scoreboard.sv
// Register scoreboard: one pending bit per architectural register.
// A bit is set when an instruction that writes that register issues and is
// cleared when the writeback for that register arrives. Also reports RAW/WAW
// hazards for the instruction currently being offered, taking a same-cycle
// writeback into account (that writeback resolves the hazard).
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   set_i, set_reg_i    : mark a register pending (issue of a writer)
//   clr_i, clr_reg_i    : writeback; clears the register's pending bit
//   src_1_i, src_2_i    : source indices of the offered instruction
//   uses_src_i          : bit0 = source 1 read, bit1 = source 2 read
//   dest_i              : destination index of the offered instruction
//   writes_dest_i       : offered instruction writes dest_i
//   hazard_o            : RAW or WAW hazard present
//   pending_o           : pending bitmap
module reg_scoreboard #(
  parameter int  REG_ADDR_WIDTH = cpu_pkg::REG_ADDR_WIDTH,
  localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      set_i,
  input  logic [REG_ADDR_WIDTH-1:0] set_reg_i,
  input  logic                      clr_i,
  input  logic [REG_ADDR_WIDTH-1:0] clr_reg_i,
  input  logic [REG_ADDR_WIDTH-1:0] src_1_i,
  input  logic [REG_ADDR_WIDTH-1:0] src_2_i,
  input  logic [1:0]                uses_src_i,
  input  logic [REG_ADDR_WIDTH-1:0] dest_i,
  input  logic                      writes_dest_i,
  output logic                      hazard_o,
  output logic [NUM_REGS-1:0]       pending_o
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  // Per-bit next state. The set term is ORed in after the clear so that an
  // issue and a writeback hitting the same register leave it pending: the
  // new writer's result is still outstanding. A writeback to a register that
  // is not pending simply leaves the bit at 0.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
    localparam logic [REG_ADDR_WIDTH-1:0] REG_IDX = REG_ADDR_WIDTH'(gi);
    assign pending_d[gi] = (set_i && (set_reg_i == REG_IDX)) ||
                           (pending_q[gi] && !(clr_i && (clr_reg_i == REG_IDX)));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // A writeback landing this cycle satisfies the dependency, because its data
  // is forwarded into the operand register on the same edge.
  logic raw_1, raw_2, waw;
  assign raw_1 = uses_src_i[0] && pending_q[src_1_i] && !(clr_i && (clr_reg_i == src_1_i));
  assign raw_2 = uses_src_i[1] && pending_q[src_2_i] && !(clr_i && (clr_reg_i == src_2_i));
  assign waw   = writes_dest_i && pending_q[dest_i]  && !(clr_i && (clr_reg_i == dest_i));

  assign hazard_o  = raw_1 || raw_2 || waw;
  assign pending_o = pending_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage. Accepts one instruction per cycle when the output slot
// is free and no register hazard exists, reads both sources from the register
// file (forwarding a same-cycle writeback), and presents the instruction with
// its operands one cycle later in a single-entry output register.
// Ports:
//   CPU_CLOCK, CLEAR                 : clock, asynchronous active-high reset
//   IN_*                             : upstream valid/ready instruction
//   READ_REG_n / READ_DATA_n         : combinational register file read
//   WB_VALID / WB_REG / WB_DATA      : writeback (same as RF write port)
//   OUT_*                            : downstream valid/ready instruction
//   PENDING                          : scoreboard bitmap (debug)
module operand_fetch #(
  parameter int DATA_WIDTH     = cpu_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = cpu_pkg::REG_ADDR_WIDTH,
  parameter int OPCODE_WIDTH   = cpu_pkg::OPCODE_WIDTH
) (
  input  logic                           CPU_CLOCK,
  input  logic                           CLEAR,
  input  logic                           IN_VALID,
  output logic                           IN_READY,
  input  logic [OPCODE_WIDTH-1:0]        IN_OPCODE,
  input  logic [REG_ADDR_WIDTH-1:0]      IN_SRC_1,
  input  logic [REG_ADDR_WIDTH-1:0]      IN_SRC_2,
  input  logic [1:0]                     IN_USES_SRC,
  input  logic [REG_ADDR_WIDTH-1:0]      IN_DEST,
  input  logic                           IN_WRITES_DEST,
  output logic [REG_ADDR_WIDTH-1:0]      READ_REG_1,
  output logic [REG_ADDR_WIDTH-1:0]      READ_REG_2,
  input  logic [DATA_WIDTH-1:0]          READ_DATA_1,
  input  logic [DATA_WIDTH-1:0]          READ_DATA_2,
  input  logic                           WB_VALID,
  input  logic [REG_ADDR_WIDTH-1:0]      WB_REG,
  input  logic [DATA_WIDTH-1:0]          WB_DATA,
  output logic                           OUT_VALID,
  input  logic                           OUT_READY,
  output logic [OPCODE_WIDTH-1:0]        OUT_OPCODE,
  output logic [DATA_WIDTH-1:0]          OUT_OPERAND_1,
  output logic [DATA_WIDTH-1:0]          OUT_OPERAND_2,
  output logic [REG_ADDR_WIDTH-1:0]      OUT_DEST,
  output logic                           OUT_WRITES_DEST,
  output logic [(1<<REG_ADDR_WIDTH)-1:0] PENDING
);

  logic                      out_valid_q, out_valid_d;
  logic [OPCODE_WIDTH-1:0]   out_opcode_q, out_opcode_d;
  logic [DATA_WIDTH-1:0]     out_op_1_q, out_op_1_d;
  logic [DATA_WIDTH-1:0]     out_op_2_q, out_op_2_d;
  logic [REG_ADDR_WIDTH-1:0] out_dest_q, out_dest_d;
  logic                      out_writes_q, out_writes_d;

  logic hazard;
  logic out_free;
  logic accept;

  assign READ_REG_1 = IN_SRC_1;
  assign READ_REG_2 = IN_SRC_2;

  // The slot is free if empty or being drained this cycle. IN_VALID is kept
  // out of IN_READY to avoid a combinational loop with upstream.
  assign out_free = !out_valid_q || OUT_READY;
  assign IN_READY = out_free && !hazard;
  assign accept   = IN_VALID && IN_READY;

  reg_scoreboard #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_scoreboard (
    .clk_i        (CPU_CLOCK),
    .rst_i        (CLEAR),
    .set_i        (accept && IN_WRITES_DEST),
    .set_reg_i    (IN_DEST),
    .clr_i        (WB_VALID),
    .clr_reg_i    (WB_REG),
    .src_1_i      (IN_SRC_1),
    .src_2_i      (IN_SRC_2),
    .uses_src_i   (IN_USES_SRC),
    .dest_i       (IN_DEST),
    .writes_dest_i(IN_WRITES_DEST),
    .hazard_o     (hazard),
    .pending_o    (PENDING)
  );

  // Operand selection: a writeback in flight this cycle has not reached the
  // register file yet, so its data is taken directly. Unused sources read 0.
  logic [DATA_WIDTH-1:0] fwd_1, fwd_2;
  always_comb begin
    fwd_1 = '0;
    fwd_2 = '0;
    if (IN_USES_SRC[0]) begin
      fwd_1 = (WB_VALID && (WB_REG == IN_SRC_1)) ? WB_DATA : READ_DATA_1;
    end
    if (IN_USES_SRC[1]) begin
      fwd_2 = (WB_VALID && (WB_REG == IN_SRC_2)) ? WB_DATA : READ_DATA_2;
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_opcode_d = out_opcode_q;
    out_op_1_d   = out_op_1_q;
    out_op_2_d   = out_op_2_q;
    out_dest_d   = out_dest_q;
    out_writes_d = out_writes_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_opcode_d = IN_OPCODE;
      out_op_1_d   = fwd_1;
      out_op_2_d   = fwd_2;
      out_dest_d   = IN_DEST;
      out_writes_d = IN_WRITES_DEST;
    end else if (OUT_READY) begin
      // Drained with nothing to replace it; data fields keep their values.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CPU_CLOCK or posedge CLEAR) begin
    if (CLEAR) begin
      out_valid_q  <= 1'b0;
      out_opcode_q <= '0;
      out_op_1_q   <= '0;
      out_op_2_q   <= '0;
      out_dest_q   <= '0;
      out_writes_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_opcode_q <= out_opcode_d;
      out_op_1_q   <= out_op_1_d;
      out_op_2_q   <= out_op_2_d;
      out_dest_q   <= out_dest_d;
      out_writes_q <= out_writes_d;
    end
  end

  assign OUT_VALID       = out_valid_q;
  assign OUT_OPCODE      = out_opcode_q;
  assign OUT_OPERAND_1   = out_op_1_q;
  assign OUT_OPERAND_2   = out_op_2_q;
  assign OUT_DEST        = out_dest_q;
  assign OUT_WRITES_DEST = out_writes_q;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        CLEAR = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [3:0]  IN_OPCODE = '0;
  logic [3:0]  IN_SRC_1 = '0;
  logic [3:0]  IN_SRC_2 = '0;
  logic [1:0]  IN_USES_SRC = '0;
  logic [3:0]  IN_DEST = '0;
  logic        IN_WRITES_DEST = 1'b0;
  logic [3:0]  READ_REG_1, READ_REG_2;
  logic [17:0] READ_DATA_1, READ_DATA_2;
  logic        WB_VALID = 1'b0;
  logic [3:0]  WB_REG = '0;
  logic [17:0] WB_DATA = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [3:0]  OUT_OPCODE;
  logic [17:0] OUT_OPERAND_1, OUT_OPERAND_2;
  logic [3:0]  OUT_DEST;
  logic        OUT_WRITES_DEST;
  logic [15:0] PENDING;

  always #5 clk = ~clk;

  operand_fetch dut (
    .CPU_CLOCK(clk), .CLEAR(CLEAR),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_OPCODE(IN_OPCODE),
    .IN_SRC_1(IN_SRC_1), .IN_SRC_2(IN_SRC_2), .IN_USES_SRC(IN_USES_SRC),
    .IN_DEST(IN_DEST), .IN_WRITES_DEST(IN_WRITES_DEST),
    .READ_REG_1(READ_REG_1), .READ_REG_2(READ_REG_2),
    .READ_DATA_1(READ_DATA_1), .READ_DATA_2(READ_DATA_2),
    .WB_VALID(WB_VALID), .WB_REG(WB_REG), .WB_DATA(WB_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_OPCODE(OUT_OPCODE),
    .OUT_OPERAND_1(OUT_OPERAND_1), .OUT_OPERAND_2(OUT_OPERAND_2),
    .OUT_DEST(OUT_DEST), .OUT_WRITES_DEST(OUT_WRITES_DEST), .PENDING(PENDING)
  );

  // Register file model: combinational read, written by the writeback port.
  logic [17:0] regs [16];
  always @(posedge clk) begin
    if (WB_VALID) regs[WB_REG] <= WB_DATA;
  end
  assign READ_DATA_1 = regs[READ_REG_1];
  assign READ_DATA_2 = regs[READ_REG_2];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0]  opc;
    logic [17:0] op1;
    logic [17:0] op2;
    logic [3:0]  dest;
    logic        wd;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [17:0] exp_operand(input logic used, input logic [3:0] src);
    if (!used) return '0;
    if (WB_VALID && (WB_REG == src)) return WB_DATA;
    return regs[src];
  endfunction

  // One clock cycle: settle, check IN_READY, push expected output on
  // acceptance, cross the edge, then pop and compare the produced output.
  task automatic run_cycle(input string name, input logic chk_ready, input logic exp_ready);
    logic acc;
    exp_t e;
    #1;
    if (chk_ready) check({name, " in_ready"}, IN_READY, exp_ready);
    acc = IN_VALID && IN_READY;
    if (acc) begin
      e.opc  = IN_OPCODE;
      e.op1  = exp_operand(IN_USES_SRC[0], IN_SRC_1);
      e.op2  = exp_operand(IN_USES_SRC[1], IN_SRC_2);
      e.dest = IN_DEST;
      e.wd   = IN_WRITES_DEST;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (acc) begin
      e = exp_q.pop_front();
      $display("%s: accepted opc=%0h op1=%05h op2=%05h dest=%0d", name, e.opc, e.op1, e.op2, e.dest);
      check({name, " out_valid"}, OUT_VALID, 1'b1);
      check({name, " out_opcode"}, OUT_OPCODE, e.opc);
      check({name, " out_operand_1"}, OUT_OPERAND_1, e.op1);
      check({name, " out_operand_2"}, OUT_OPERAND_2, e.op2);
      check({name, " out_dest"}, OUT_DEST, e.dest);
      check({name, " out_writes_dest"}, OUT_WRITES_DEST, e.wd);
    end else begin
      $display("%s: no acceptance", name);
    end
  endtask

  task automatic drive_in(input logic v, input logic [3:0] opc, input logic [3:0] s1,
                          input logic [3:0] s2, input logic [1:0] uses,
                          input logic [3:0] dest, input logic wd);
    IN_VALID = v; IN_OPCODE = opc; IN_SRC_1 = s1; IN_SRC_2 = s2;
    IN_USES_SRC = uses; IN_DEST = dest; IN_WRITES_DEST = wd;
  endtask

  typedef struct {
    logic        in_valid;
    logic [3:0]  opcode;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [1:0]  uses;
    logic [3:0]  dest;
    logic        wd;
    logic        wb_valid;
    logic [3:0]  wb_reg;
    logic [17:0] wb_data;
    logic        out_ready;
    logic        exp_in_ready;
    logic [15:0] exp_pending;
    logic        exp_out_valid;
  } vec_t;
  vec_t tv [9];

  initial begin
    // plain issue
    tv[0] = '{1'b1, 4'hA, 4'd3, 4'd4, 2'b11, 4'd5, 1'b1, 1'b0, 4'd0, 18'h0,     1'b1, 1'b1, 16'h0020, 1'b1};
    // RAW on R5: stalls
    tv[1] = '{1'b1, 4'h2, 4'd5, 4'd0, 2'b01, 4'd6, 1'b1, 1'b0, 4'd0, 18'h0,     1'b1, 1'b0, 16'h0020, 1'b0};
    tv[2] = '{1'b1, 4'h2, 4'd5, 4'd0, 2'b01, 4'd6, 1'b1, 1'b0, 4'd0, 18'h0,     1'b1, 1'b0, 16'h0020, 1'b0};
    // writeback of R5 releases and forwards
    tv[3] = '{1'b1, 4'h2, 4'd5, 4'd0, 2'b01, 4'd6, 1'b1, 1'b1, 4'd5, 18'h3FFFF, 1'b1, 1'b1, 16'h0040, 1'b1};
    // WAW on R6: stalls
    tv[4] = '{1'b1, 4'h6, 4'd0, 4'd0, 2'b00, 4'd6, 1'b1, 1'b0, 4'd0, 18'h0,     1'b1, 1'b0, 16'h0040, 1'b0};
    // IN_READY with IN_VALID=0 while R6 writeback bypasses the WAW
    tv[5] = '{1'b0, 4'h6, 4'd0, 4'd0, 2'b00, 4'd6, 1'b1, 1'b1, 4'd6, 18'h12345, 1'b1, 1'b1, 16'h0000, 1'b0};
    // writeback to a non-pending register is ignored
    tv[6] = '{1'b0, 4'h0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b1, 4'd9, 18'h00999, 1'b1, 1'b1, 16'h0000, 1'b0};
    // issue reading the written-back registers, then back-to-back issue
    tv[7] = '{1'b1, 4'h3, 4'd6, 4'd5, 2'b11, 4'd15, 1'b1, 1'b0, 4'd0, 18'h0,    1'b1, 1'b1, 16'h8000, 1'b1};
    tv[8] = '{1'b1, 4'h1, 4'd3, 4'd4, 2'b11, 4'd0, 1'b1, 1'b0, 4'd0, 18'h0,     1'b1, 1'b1, 16'h8001, 1'b1};

    // Load the register file through the writeback port while in reset.
    for (int r = 0; r < 16; r++) begin
      WB_VALID = 1'b1;
      WB_REG   = 4'(r);
      WB_DATA  = (r == 3) ? 18'h00005 : (r == 4) ? 18'h00007 : 18'(r * 'h1111);
      @(posedge clk);
      #1;
    end
    WB_VALID = 1'b0;
    check("reset out_valid", OUT_VALID, 1'b0);
    check("reset pending", PENDING, 16'h0000);
    check("reset out_operand_1", OUT_OPERAND_1, 18'h0);
    CLEAR = 1'b0;
    #1;
    check("idle in_ready", IN_READY, 1'b1);

    for (int i = 0; i < 9; i++) begin
      drive_in(tv[i].in_valid, tv[i].opcode, tv[i].src1, tv[i].src2, tv[i].uses, tv[i].dest, tv[i].wd);
      WB_VALID  = tv[i].wb_valid;
      WB_REG    = tv[i].wb_reg;
      WB_DATA   = tv[i].wb_data;
      OUT_READY = tv[i].out_ready;
      run_cycle($sformatf("v%0d", i), 1'b1, tv[i].exp_in_ready);
      check($sformatf("v%0d pending", i), PENDING, tv[i].exp_pending);
      check($sformatf("v%0d out_valid", i), OUT_VALID, tv[i].exp_out_valid);
    end

    // Reset pulsed between edges with an entry held and two pending bits.
    drive_in(1'b0, 4'h0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0);
    WB_VALID  = 1'b0;
    OUT_READY = 1'b0;
    @(negedge clk);
    check("pre-clear out_valid", OUT_VALID, 1'b1);
    check("pre-clear pending", PENDING, 16'h8001);
    #1 CLEAR = 1'b1;
    #1;
    check("clear out_valid", OUT_VALID, 1'b0);
    check("clear pending", PENDING, 16'h0000);
    check("clear out_opcode", OUT_OPCODE, 4'h0);
    check("clear out_operand_1", OUT_OPERAND_1, 18'h0);
    check("clear out_operand_2", OUT_OPERAND_2, 18'h0);
    check("clear out_dest", OUT_DEST, 4'h0);
    check("clear out_writes_dest", OUT_WRITES_DEST, 1'b0);
    $display("clear: pulsed between edges");
    #1 CLEAR = 1'b0;

    // Back-pressure: first acceptance right after reset, then hold 3 cycles.
    OUT_READY = 1'b1;
    drive_in(1'b1, 4'hC, 4'd5, 4'd6, 2'b11, 4'd7, 1'b1);
    run_cycle("bp0", 1'b1, 1'b1);
    check("bp0 pending", PENDING, 16'h0080);
    drive_in(1'b1, 4'hD, 4'd3, 4'd4, 2'b11, 4'd8, 1'b1);
    OUT_READY = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      run_cycle($sformatf("bp%0d", k), 1'b1, 1'b0);
      check($sformatf("bp%0d out_valid", k), OUT_VALID, 1'b1);
      check($sformatf("bp%0d out_opcode", k), OUT_OPCODE, 4'hC);
      check($sformatf("bp%0d out_operand_1", k), OUT_OPERAND_1, 18'h3FFFF);
      check($sformatf("bp%0d out_operand_2", k), OUT_OPERAND_2, 18'h12345);
      check($sformatf("bp%0d pending", k), PENDING, 16'h0080);
    end
    OUT_READY = 1'b1;
    run_cycle("bp4", 1'b1, 1'b1);
    check("bp4 pending", PENDING, 16'h0180);
    drive_in(1'b0, 4'h0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0);
    run_cycle("bp5", 1'b0, 1'b0);
    check("bp5 out_valid", OUT_VALID, 1'b0);

    // WAW collision: writeback of R2 and a new writer of R2 in one cycle.
    drive_in(1'b1, 4'h2, 4'd0, 4'd0, 2'b00, 4'd2, 1'b1);
    run_cycle("waw0", 1'b1, 1'b1);
    check("waw0 pending", PENDING, 16'h0184);
    drive_in(1'b1, 4'h4, 4'd0, 4'd0, 2'b00, 4'd2, 1'b1);
    WB_VALID = 1'b1;
    WB_REG   = 4'd2;
    WB_DATA  = 18'h00ABC;
    run_cycle("waw1", 1'b1, 1'b1);
    check("waw1 pending", PENDING, 16'h0184);
    WB_VALID = 1'b0;
    drive_in(1'b0, 4'h0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0);
    run_cycle("drain", 1'b0, 1'b0);
    check("drain out_valid", OUT_VALID, 1'b0);
    check("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
